// File: rtl/frame_packetizer_pkg.sv
// Shared definitions for the frame packetizer: sync bytes, FSM state type, address-width helper.
// The CSUM state exists only when FRAME_PACKETIZER_CHECKSUM_EN is defined.
package frame_pkg;

   localparam logic [7:0] SYNC0_BYTE = 8'hAA;
   localparam logic [7:0] SYNC1_BYTE = 8'h55;

   typedef enum logic [2:0] {
      IDLE,
      SYNC0,
      SYNC1,
      SEQ,
      FETCH,
      LOAD,
      SEND
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
      , CSUM
`endif
   } frame_state_t;

   // A one-entry bank still needs a one-bit address.
   function automatic int unsigned addr_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/frame_packetizer_if.sv
// Byte stream from the packetizer to the UART transmitter (valid/ready).
interface frame_packetizer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/frame_packetizer.sv
// Serializes a snapshot bank into a sync/seq/payload byte frame on a valid/ready stream.
// Define FRAME_PACKETIZER_CHECKSUM_EN to append a modulo-256 checksum byte.
module frame_packetizer
   import frame_pkg::*;
#(
   parameter int NUM_INPUTS      = 12,
   parameter int RESOLUTION      = 16,
   parameter int NUM_CORRELATORS = NUM_INPUTS * (NUM_INPUTS - 1) / 2,
   parameter int NUM_WORDS       = NUM_INPUTS + NUM_CORRELATORS
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                integration_clk_pulse,
   output logic [addr_width(NUM_WORDS)-1:0]    rd_addr,
   input  logic [RESOLUTION-1:0]               rd_data,
   frame_packetizer_if.master                  tx,
   output logic                                busy,
   output logic                                overrun
);

   localparam int AW    = addr_width(NUM_WORDS);
   localparam int BYTES = RESOLUTION / 8;
   localparam int BCW   = addr_width(BYTES);
   localparam logic [AW-1:0]  LAST_ADDR     = AW'(NUM_WORDS - 1);
   localparam logic [BCW-1:0] BYTE_CNT_INIT = BCW'(BYTES - 1);

   frame_state_t          state_q, state_d;
   logic [7:0]            seq_q, seq_d;
   logic [AW-1:0]         rd_addr_q, rd_addr_d;
   logic [RESOLUTION-1:0] shift_q, shift_d;
   logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  tx_valid_q, tx_valid_d;
   logic                  busy_q, busy_d;
   logic                  overrun_q, overrun_d;
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_d;
`endif

   logic xfer;
   logic start;

   assign xfer = tx_valid_q && tx.tx_ready;

   always_comb begin
      state_d    = state_q;
      seq_d      = seq_q;
      rd_addr_d  = rd_addr_q;
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      overrun_d  = 1'b0;
      start      = 1'b0;
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
      csum_d     = csum_q;
`endif

      case (state_q)
         IDLE: begin
            start = integration_clk_pulse;
         end
         SYNC0: begin
            if (xfer) begin
               state_d   = SYNC1;
               tx_data_d = SYNC1_BYTE;
            end
         end
         SYNC1: begin
            if (xfer) begin
               state_d   = SEQ;
               tx_data_d = seq_q;
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
               csum_d    = seq_q;
`endif
            end
         end
         SEQ: begin
            if (xfer) begin
               state_d    = FETCH;
               tx_valid_d = 1'b0;
               rd_addr_d  = '0;
               seq_d      = seq_q + 8'd1;
            end
         end
         FETCH: begin
            state_d = LOAD;
         end
         LOAD: begin
            // First byte goes straight to the output register; the rest wait in the shifter.
            state_d    = SEND;
            tx_valid_d = 1'b1;
            tx_data_d  = rd_data[RESOLUTION-1 -: 8];
            shift_d    = rd_data << 8;
            byte_cnt_d = BYTE_CNT_INIT;
         end
         SEND: begin
            if (xfer) begin
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
               csum_d = csum_q + tx_data_q;
`endif
               if (byte_cnt_q != '0) begin
                  tx_data_d  = shift_q[RESOLUTION-1 -: 8];
                  shift_d    = shift_q << 8;
                  byte_cnt_d = byte_cnt_q - BCW'(1);
               end else if (rd_addr_q != LAST_ADDR) begin
                  state_d    = FETCH;
                  tx_valid_d = 1'b0;
                  rd_addr_d  = rd_addr_q + AW'(1);
               end else begin
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
                  state_d   = CSUM;
                  tx_data_d = csum_q + tx_data_q;
`else
                  state_d    = IDLE;
                  tx_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  start      = integration_clk_pulse;
`endif
               end
            end
         end
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
         CSUM: begin
            if (xfer) begin
               state_d    = IDLE;
               tx_valid_d = 1'b0;
               busy_d     = 1'b0;
               start      = integration_clk_pulse;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase

      // A strobe on the final transfer chains straight into the next frame.
      if (start) begin
         state_d    = SYNC0;
         tx_valid_d = 1'b1;
         tx_data_d  = SYNC0_BYTE;
         busy_d     = 1'b1;
      end else if (integration_clk_pulse && busy_q) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         seq_q      <= '0;
         rd_addr_q  <= '0;
         shift_q    <= '0;
         byte_cnt_q <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         seq_q      <= seq_d;
         rd_addr_q  <= rd_addr_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign rd_addr     = rd_addr_q;
   assign tx.tx_data  = tx_data_q;
   assign tx.tx_valid = tx_valid_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_frame_packetizer.sv
// Directed-plus-random bench for frame_packetizer with a queue-based frame model.
module tb_frame_packetizer;
   import frame_pkg::*;

   localparam int NI  = 12;
   localparam int RES = 16;
   localparam int NW  = NI + NI * (NI - 1) / 2;
   localparam int AW  = addr_width(NW);
   localparam int NB  = RES / 8;
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
   localparam int FRAME_LEN = 3 + NW * NB + 1;
`else
   localparam int FRAME_LEN = 3 + NW * NB;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic           strobe;
   logic [AW-1:0]  rd_addr;
   logic [RES-1:0] rd_data;
   logic           busy;
   logic           overrun;

   frame_packetizer_if bus();

   frame_packetizer #(.NUM_INPUTS(NI), .RESOLUTION(RES)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .integration_clk_pulse (strobe),
      .rd_addr               (rd_addr),
      .rd_data               (rd_data),
      .tx                    (bus),
      .busy                  (busy),
      .overrun               (overrun)
   );

   always #5 clk = ~clk;

   logic [RES-1:0] snap [NW];
   always @(posedge clk) rd_data <= snap[rd_addr];

   int         n_cmp = 0;
   int         n_fail = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int         cyc = 0;
   int         last_xfer_cyc = 0;
   int         ovr_seen = 0;
   int         ready_pct = 100;
   logic [7:0] exp_seq;
   logic [7:0] stall_data;
   bit         stall_prev = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stream monitor: records accepted bytes and enforces hold-under-backpressure.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
            check("hold_data", {24'd0, bus.tx_data}, {24'd0, stall_data});
         end
         if (overrun === 1'b1) ovr_seen++;
         if (bus.tx_valid && bus.tx_ready) begin
            rx_q.push_back(bus.tx_data);
            last_xfer_cyc = cyc;
         end
         stall_prev = bus.tx_valid && !bus.tx_ready;
         stall_data = bus.tx_data;
      end
   end

   initial begin
      bus.tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.tx_ready = ($urandom_range(99) < ready_pct);
      end
   end

   // Reference frame: sync, seq, words MSB-byte-first, optional sum of seq+payload.
   function automatic void build_frame(input logic [7:0] s);
      logic [7:0] sum;
      logic [7:0] b;
      exp_q.delete();
      exp_q.push_back(8'hAA);
      exp_q.push_back(8'h55);
      exp_q.push_back(s);
      sum = s;
      for (int w = 0; w < NW; w++) begin
         for (int k = NB - 1; k >= 0; k--) begin
            b = 8'((snap[w] >> (8 * k)) & 'hFF);
            exp_q.push_back(b);
            sum = sum + b;
         end
      end
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
      exp_q.push_back(sum);
`endif
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic start_frame(input string tag);
      build_frame(exp_seq);
      exp_seq = exp_seq + 8'd1;
      rx_q.delete();
      strobe = 1'b1;
      @(posedge clk);
      #1;
      strobe = 1'b0;
      tick();
      check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
      check({tag, "_valid_rise"}, {31'd0, bus.tx_valid}, 32'd1);
      check({tag, "_first_byte"}, {24'd0, bus.tx_data}, 32'hAA);
   endtask

   task automatic compare_frame(input string tag);
      int bad;
      int n;
      bad = -1;
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      check({tag, "_len"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < n; i++)
         if (bad < 0 && rx_q[i] !== exp_q[i]) bad = i;
      check({tag, "_first_bad_idx"}, bad, 32'hFFFF_FFFF);
   endtask

   task automatic wait_end(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 20000) begin
         tick();
         n++;
      end
      check({tag, "_end_timeout"}, {31'd0, busy}, 32'd0);
      check({tag, "_busy_fall"}, cyc, last_xfer_cyc + 1);
      compare_frame(tag);
   endtask

   task automatic wait_bytes(input string tag, input int count);
      int n;
      n = 0;
      while (rx_q.size() < count && n < 20000) begin
         tick();
         n++;
      end
      check({tag, "_byte_timeout"}, (rx_q.size() >= count) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      int ovr0;
      int n;
      strobe  = 1'b0;
      reset   = 1'b1;
      exp_seq = 8'd0;
      for (int k = 0; k < NW; k++) snap[k] = RES'(16'h0100 + k);
      repeat (3) tick();
      check("rst_valid", {31'd0, bus.tx_valid}, 32'd0);
      check("rst_data", {24'd0, bus.tx_data}, 32'd0);
      check("rst_addr", 32'(rd_addr), 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      reset = 1'b0;
      tick();

      // Basic frame with a ramp pattern.
      start_frame("basic");
      wait_end("basic");
      check("basic_len_const", rx_q.size(), FRAME_LEN);
      check("basic_byte3", {24'd0, rx_q[3]}, 32'h01);
`ifndef FRAME_PACKETIZER_CHECKSUM_EN
      check("basic_last", {24'd0, rx_q[rx_q.size() - 1]}, 32'h4D);
`endif

      // Random data under 30% ready duty.
      ready_pct = 30;
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < NW; k++) snap[k] = RES'($urandom);
         start_frame("backpressure");
         wait_end("backpressure");
      end
      ready_pct = 100;
      tick();

      // Strobe at byte 40 is dropped with a single overrun pulse.
      ovr0 = ovr_seen;
      start_frame("overrun");
      wait_bytes("overrun", 40);
      strobe = 1'b1;
      @(posedge clk);
      #1;
      strobe = 1'b0;
      tick();
      check("overrun_pulse", {31'd0, overrun}, 32'd1);
      tick();
      check("overrun_single", {31'd0, overrun}, 32'd0);
      wait_end("overrun");
      check("overrun_count", ovr_seen - ovr0, 32'd1);

      // Strobe coincident with the final transfer.
      start_frame("b2b_a");
      n = 0;
      while (rx_q.size() < exp_q.size() && n < 20000) begin
         tick();
         n++;
      end
      check("b2b_wait", rx_q.size(), exp_q.size());
      strobe = 1'b1;
      @(posedge clk);
      #1;
      strobe = 1'b0;
      compare_frame("b2b_a");
      build_frame(exp_seq);
      exp_seq = exp_seq + 8'd1;
      rx_q.delete();
      tick();
      check("b2b_valid", {31'd0, bus.tx_valid}, 32'd1);
      check("b2b_data", {24'd0, bus.tx_data}, 32'hAA);
      check("b2b_busy", {31'd0, busy}, 32'd1);
      check("b2b_no_overrun", {31'd0, overrun}, 32'd0);
      wait_end("b2b_b");

      // Reset mid-frame clears everything immediately.
      start_frame("midrst");
      wait_bytes("midrst", 20);
      reset = 1'b1;
      #1;
      check("midrst_valid", {31'd0, bus.tx_valid}, 32'd0);
      check("midrst_data", {24'd0, bus.tx_data}, 32'd0);
      check("midrst_addr", 32'(rd_addr), 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_overrun", {31'd0, overrun}, 32'd0);
      tick();
      reset   = 1'b0;
      exp_seq = 8'd0;
      tick();
      start_frame("postrst");
      wait_end("postrst");
      check("postrst_seq", {24'd0, rx_q[2]}, 32'h00);

      // All-ones payload with seq 0.
      reset = 1'b1;
      tick();
      reset   = 1'b0;
      exp_seq = 8'd0;
      for (int k = 0; k < NW; k++) snap[k] = '1;
      tick();
      start_frame("ones");
      wait_end("ones");
`ifdef FRAME_PACKETIZER_CHECKSUM_EN
      check("ones_len", rx_q.size(), 32'd160);
      check("ones_csum", {24'd0, rx_q[rx_q.size() - 1]}, 32'h64);
`endif

      // Random frames, random backpressure.
      ready_pct = 50;
      for (int f = 0; f < 2; f++) begin
         for (int k = 0; k < NW; k++) snap[k] = RES'($urandom);
         start_frame("random");
         wait_end("random");
      end

      check("total_overruns", ovr_seen, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
